iq_issue_select: RTL and testbench

Allocation and issue-select controller for one issue queue. Tracks which `iq_entry` slots are occupied and assigns free slots to instructions arriving from dispatch. Keeps the relative age of all occupied entries and, each cycle, picks the oldest entry whose operands are ready. Presents that pick to the execute unit through a registered valid/ready handshake. Sits between dispatch and the array of `iq_entry` instances, and drives their select and clear strobes.

---
 rtl/iq_issue_select_pkg.sv | 9 +
 rtl/iq_age_matrix.sv | 55 +++++
 rtl/iq_issue_select.sv | 122 ++++++++++++
 tb/tb_iq_issue_select.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_issue_select_pkg.sv
// Shared types and default sizing for the issue-queue allocation/select slice.
package iq_issue_select_pkg;

  localparam int IQ_SIZE_DEFAULT = 8;
  localparam int IQ_IDX_W        = $clog2(IQ_SIZE_DEFAULT);

  typedef logic [IQ_IDX_W-1:0] iq_idx_t;

endpackage

// File: rtl/iq_age_matrix.sv
// Relative-age matrix for the issue queue; older_q[i][j]=1 means entry i is older than j.
// Instantiated only when IQ_AGE_SELECT_EN is defined.
module iq_age_matrix
  import iq_issue_select_pkg::*;
#(
  parameter int IQ_SIZE = IQ_SIZE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [IQ_SIZE-1:0] occ,
  input  logic [IQ_SIZE-1:0] alloc0_oh,
  input  logic [IQ_SIZE-1:0] alloc1_oh,
  input  logic [IQ_SIZE-1:0] clr_oh,
  input  logic [IQ_SIZE-1:0] req,
  output logic [IQ_SIZE-1:0] oldest_oh
);

  logic [IQ_SIZE-1:0] older_q [IQ_SIZE];
  logic [IQ_SIZE-1:0] older_d [IQ_SIZE];

  // A new entry is younger than everything already resident; slot 0 beats slot 1.
  always_comb begin
    for (int i = 0; i < IQ_SIZE; i++) begin
      older_d[i] = older_q[i];
      if (clr_oh[i] || alloc0_oh[i] || alloc1_oh[i]) older_d[i] = '0;
      for (int j = 0; j < IQ_SIZE; j++) begin
        if (alloc0_oh[j]) older_d[i][j] = occ[i];
        if (alloc1_oh[j]) older_d[i][j] = occ[i] | alloc0_oh[i];
      end
    end
  end

  // NOTE: the matrix is a small flop array, so it takes the async reset; stale
  // bits would otherwise be X and poison the first select after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IQ_SIZE; i++) older_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < IQ_SIZE; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < IQ_SIZE; i++) older_q[i] <= older_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < IQ_SIZE; i++) begin
      oldest_oh[i] = req[i];
      for (int j = 0; j < IQ_SIZE; j++) begin
        if (req[j] && older_q[j][i]) oldest_oh[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/iq_issue_select.sv
// Issue-queue allocation and issue-select controller with a registered valid/ready issue port.
// Define IQ_AGE_SELECT_EN for oldest-first select; otherwise lowest-index candidate wins.
module iq_issue_select
  import iq_issue_select_pkg::*;
#(
  parameter int IQ_SIZE    = IQ_SIZE_DEFAULT,
  parameter int DISPATCH_W = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic [DISPATCH_W-1:0]                 alloc_valid_i,
  output logic                                  alloc_ready_o,
  output logic [DISPATCH_W*$clog2(IQ_SIZE)-1:0] alloc_idx_o,
  output logic [IQ_SIZE-1:0]                    entry_sel_o,
  input  logic [IQ_SIZE-1:0]                    entry_ready_i,
  output logic                                  issue_valid_o,
  output logic [$clog2(IQ_SIZE)-1:0]            issue_idx_o,
  input  logic                                  issue_ready_i,
  output logic [IQ_SIZE-1:0]                    entry_clr_o,
  output logic [$clog2(IQ_SIZE):0]              free_cnt_o
);

  localparam int IDX_W = $clog2(IQ_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [IQ_SIZE-1:0] occ_q, held_q, cand, win_oh, alloc0_oh, alloc1_oh;
  logic [IDX_W-1:0]   idx0, idx1, win_idx;
  logic               found0, found1, acc0, acc1, hs, load, any_cand;

  // Two lowest free entries and the free count, all from registered occupancy.
  always_comb begin
    idx0       = '0;
    idx1       = '0;
    found0     = 1'b0;
    found1     = 1'b0;
    free_cnt_o = CNT_W'(IQ_SIZE);
    for (int i = 0; i < IQ_SIZE; i++) begin
      if (occ_q[i]) begin
        free_cnt_o = free_cnt_o - CNT_W'(1);
      end else if (!found0) begin
        idx0   = IDX_W'(i);
        found0 = 1'b1;
      end else if (!found1) begin
        idx1   = IDX_W'(i);
        found1 = 1'b1;
      end
    end
  end

  assign alloc_ready_o = (free_cnt_o >= CNT_W'(2));
  assign alloc_idx_o   = {idx1, idx0};
  assign acc0          = alloc_valid_i[0] & alloc_ready_o & ~flush;
  assign acc1          = alloc_valid_i[1] & alloc_ready_o & ~flush;
  assign hs            = issue_valid_o & issue_ready_i;
  assign load          = ~issue_valid_o | hs;
  assign cand          = occ_q & entry_ready_i & ~held_q;
  assign any_cand      = |cand;
  assign entry_sel_o   = alloc0_oh | alloc1_oh;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    alloc0_oh   = '0;
    alloc1_oh   = '0;
    entry_clr_o = '0;
    if (acc0) alloc0_oh[idx0] = 1'b1;
    if (acc1) alloc1_oh[idx1] = 1'b1;
    if (hs && !flush) entry_clr_o[issue_idx_o] = 1'b1;
  end

`ifdef IQ_AGE_SELECT_EN
  iq_age_matrix #(.IQ_SIZE(IQ_SIZE)) u_age (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .occ       (occ_q),
    .alloc0_oh (alloc0_oh),
    .alloc1_oh (alloc1_oh),
    .clr_oh    (entry_clr_o),
    .req       (cand),
    .oldest_oh (win_oh)
  );
`else
  always_comb begin
    win_oh = '0;
    for (int i = 0; i < IQ_SIZE; i++) begin
      if (cand[i] && win_oh == '0) win_oh[i] = 1'b1;
    end
  end
`endif

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < IQ_SIZE; i++) begin
      if (win_oh[i]) win_idx = IDX_W'(i);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q         <= '0;
      held_q        <= '0;
      issue_valid_o <= 1'b0;
      issue_idx_o   <= '0;
    end else if (flush) begin
      occ_q         <= '0;
      held_q        <= '0;
      issue_valid_o <= 1'b0;
    end else begin
      occ_q  <= (occ_q & ~entry_clr_o) | entry_sel_o;
      held_q <= (held_q & ~entry_clr_o) | (load ? win_oh : '0);
      if (load) begin
        issue_valid_o <= any_cand;
        if (any_cand) issue_idx_o <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_iq_issue_select.sv
// Self-checking bench for iq_issue_select: directed vector table, corner sequences, random vs queue model.
module tb_iq_issue_select;
  import iq_issue_select_pkg::*;

`ifdef IQ_AGE_SELECT_EN
  localparam bit AGE_SEL = 1'b1;
`else
  localparam bit AGE_SEL = 1'b0;
`endif

  logic       clk, rst_n, flush;
  logic [1:0] alloc_valid_i;
  logic       alloc_ready_o;
  logic [5:0] alloc_idx_o;
  logic [7:0] entry_sel_o, entry_ready_i, entry_clr_o;
  logic       issue_valid_o, issue_ready_i;
  iq_idx_t    issue_idx_o;
  logic [3:0] free_cnt_o;

  iq_issue_select #(.IQ_SIZE(8), .DISPATCH_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .alloc_valid_i (alloc_valid_i),
    .alloc_ready_o (alloc_ready_o),
    .alloc_idx_o   (alloc_idx_o),
    .entry_sel_o   (entry_sel_o),
    .entry_ready_i (entry_ready_i),
    .issue_valid_o (issue_valid_o),
    .issue_idx_o   (issue_idx_o),
    .issue_ready_i (issue_ready_i),
    .entry_clr_o   (entry_clr_o),
    .free_cnt_o    (free_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: occupancy flags plus an allocation-order queue.
  bit   m_occ [8];
  int   m_age [$];
  bit   m_iv;
  int   m_iidx;
  int   e_free, e_idx0, e_idx1;
  bit   e_ready, e_acc0, e_acc1;
  logic [7:0] e_sel, e_clr;

  task automatic m_reset();
    foreach (m_occ[i]) m_occ[i] = 1'b0;
    m_age.delete();
    m_iv   = 1'b0;
    m_iidx = 0;
  endtask

  task automatic m_expect();
    int fq[$];
    e_free = 0;
    for (int i = 0; i < 8; i++) if (!m_occ[i]) begin e_free++; fq.push_back(i); end
    e_ready = (e_free >= 2);
    e_idx0  = (fq.size() > 0) ? fq[0] : 0;
    e_idx1  = (fq.size() > 1) ? fq[1] : 0;
    e_acc0  = alloc_valid_i[0] && e_ready && !flush;
    e_acc1  = alloc_valid_i[1] && e_ready && !flush;
    e_sel   = '0;
    if (e_acc0) e_sel[e_idx0] = 1'b1;
    if (e_acc1) e_sel[e_idx1] = 1'b1;
    e_clr = '0;
    if (m_iv && issue_ready_i && !flush) e_clr[m_iidx] = 1'b1;
  endtask

  task automatic m_step();
    int  held, win;
    bit  load;
    if (flush) begin
      m_reset();
      return;
    end
    held = m_iv ? m_iidx : -1;
    load = !m_iv;
    if (m_iv && issue_ready_i) begin
      load = 1'b1;
      m_occ[m_iidx] = 1'b0;
      for (int k = 0; k < m_age.size(); k++) begin
        if (m_age[k] == m_iidx) begin m_age.delete(k); break; end
      end
    end
    if (load) begin
      win = -1;
      if (AGE_SEL) begin
        foreach (m_age[k])
          if (win < 0 && m_occ[m_age[k]] && entry_ready_i[m_age[k]] && m_age[k] != held) win = m_age[k];
      end else begin
        for (int i = 0; i < 8; i++)
          if (win < 0 && m_occ[i] && entry_ready_i[i] && i != held) win = i;
      end
      m_iv = (win >= 0);
      if (win >= 0) m_iidx = win;
    end
    if (e_acc0) begin m_occ[e_idx0] = 1'b1; m_age.push_back(e_idx0); end
    if (e_acc1) begin m_occ[e_idx1] = 1'b1; m_age.push_back(e_idx1); end
  endtask

  // Outputs sampled at the falling edge of the last cycle.
  logic       s_ardy, s_iv;
  logic [3:0] s_free;
  logic [2:0] s_iidx;
  logic [7:0] s_sel, s_clr;
  logic [5:0] s_aidx;

  task automatic cycle(input logic [1:0] av, input logic [7:0] er, input logic ir, input logic fl);
    alloc_valid_i = av;
    entry_ready_i = er;
    issue_ready_i = ir;
    flush         = fl;
    @(negedge clk);
    s_ardy = alloc_ready_o; s_free = free_cnt_o; s_iv = issue_valid_o; s_iidx = issue_idx_o;
    s_sel  = entry_sel_o;   s_clr  = entry_clr_o; s_aidx = alloc_idx_o;
    m_expect();
    check("m_free_cnt", s_free, e_free);
    check("m_alloc_ready", s_ardy, e_ready);
    if (e_ready) check("m_alloc_idx", s_aidx, (e_idx1 << 3) | e_idx0);
    check("m_entry_sel", s_sel, e_sel);
    check("m_entry_clr", s_clr, e_clr);
    check("m_issue_valid", s_iv, m_iv);
    if (m_iv) check("m_issue_idx", s_iidx, m_iidx);
    @(posedge clk);
    m_step();
    #1;
  endtask

  typedef struct {
    logic [1:0] av;
    logic [7:0] er;
    logic       ir;
    logic       fl;
    logic       ardy;
    logic [3:0] free;
    logic       iv;
    logic [2:0] iidx;
    logic [7:0] sel;
    logic [7:0] clr;
    logic [5:0] aidx;
  } vec_t;

  vec_t tbl [17];
  int   hold_idx;

  initial begin
    //            av     er     ir    fl    ardy  free  iv    iidx  sel    clr    aidx
    tbl[0]  = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 3'd0, 8'h00, 8'h00, 6'd8};
    tbl[1]  = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 3'd0, 8'h03, 8'h00, 6'd8};
    tbl[2]  = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 3'd0, 8'h0C, 8'h00, 6'd26};
    tbl[3]  = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 3'd0, 8'h30, 8'h00, 6'd44};
    tbl[4]  = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 3'd0, 8'hC0, 8'h00, 6'd62};
    tbl[5]  = '{2'b11, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 8'h00, 8'h00, 6'd0};
    tbl[6]  = '{2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 8'h00, 8'h00, 6'd0};
    tbl[7]  = '{2'b11, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 8'h00, 8'h00, 6'd0};
    tbl[8]  = '{2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 4'd8, 1'b0, 3'd0, 8'h03, 8'h00, 6'd8};
    tbl[9]  = '{2'b11, 8'h00, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0, 3'd0, 8'h0C, 8'h00, 6'd26};
    tbl[10] = '{2'b00, 8'h0E, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 3'd0, 8'h00, 8'h00, 6'd44};
    tbl[11] = '{2'b00, 8'h0E, 1'b1, 1'b0, 1'b1, 4'd4, 1'b1, 3'd1, 8'h00, 8'h02, 6'd44};
    tbl[12] = '{2'b00, 8'h0E, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 3'd2, 8'h00, 8'h04, 6'd33};
    tbl[13] = '{2'b00, 8'h0E, 1'b1, 1'b0, 1'b1, 4'd6, 1'b1, 3'd3, 8'h00, 8'h08, 6'd17};
    tbl[14] = '{2'b00, 8'h0F, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 3'd0, 8'h00, 8'h00, 6'd17};
    tbl[15] = '{2'b00, 8'h0F, 1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 3'd0, 8'h00, 8'h01, 6'd17};
    tbl[16] = '{2'b00, 8'h00, 1'b1, 1'b0, 1'b1, 4'd8, 1'b0, 3'd0, 8'h00, 8'h00, 6'd8};

    rst_n = 1'b0; flush = 1'b0; alloc_valid_i = '0; entry_ready_i = '0; issue_ready_i = 1'b0;
    m_reset();
    #3;
    check("rst_issue_valid", issue_valid_o, 0);
    check("rst_issue_idx", issue_idx_o, 0);
    check("rst_free_cnt", free_cnt_o, 8);
    check("rst_alloc_ready", alloc_ready_o, 1);
    check("rst_alloc_idx", alloc_idx_o, 6'd8);
    check("rst_entry_sel", entry_sel_o, 0);
    check("rst_entry_clr", entry_clr_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vector table: fill, full, flush, in-order issue.
    for (int v = 0; v < 17; v++) begin
      cycle(tbl[v].av, tbl[v].er, tbl[v].ir, tbl[v].fl);
      check($sformatf("t%0d_alloc_ready", v), s_ardy, tbl[v].ardy);
      check($sformatf("t%0d_free_cnt", v), s_free, tbl[v].free);
      check($sformatf("t%0d_issue_valid", v), s_iv, tbl[v].iv);
      if (tbl[v].iv) check($sformatf("t%0d_issue_idx", v), s_iidx, tbl[v].iidx);
      check($sformatf("t%0d_entry_sel", v), s_sel, tbl[v].sel);
      check($sformatf("t%0d_entry_clr", v), s_clr, tbl[v].clr);
      if (tbl[v].ardy) check($sformatf("t%0d_alloc_idx", v), s_aidx, tbl[v].aidx);
    end

    // Reuse of a freed entry: age select prefers older 5 over re-allocated 1.
    cycle(2'b00, 8'h00, 1'b0, 1'b1);
    repeat (3) cycle(2'b11, 8'h00, 1'b0, 1'b0);
    cycle(2'b00, 8'h02, 1'b1, 1'b0);
    cycle(2'b00, 8'h02, 1'b1, 1'b0);
    check("reuse_clr1", s_clr, 8'h02);
    cycle(2'b01, 8'h00, 1'b0, 1'b0);
    check("reuse_sel1", s_sel, 8'h02);
    cycle(2'b00, 8'h22, 1'b0, 1'b0);
    cycle(2'b00, 8'h22, 1'b0, 1'b0);
    check("reuse_valid", s_iv, 1);
    check("reuse_pick", s_iidx, AGE_SEL ? 5 : 1);
    hold_idx = s_iidx;

    // Stalled offer: index must not move while more entries become ready.
    repeat (4) begin
      cycle(2'b00, 8'h3F, 1'b0, 1'b0);
      check("hold_idx", s_iidx, hold_idx);
      check("hold_valid", s_iv, 1);
      check("hold_no_clr", s_clr, 0);
    end
    repeat (8) cycle(2'b00, 8'h3F, 1'b1, 1'b0);

    // Flush with a full queue and a pending offer.
    cycle(2'b00, 8'h00, 1'b0, 1'b1);
    repeat (4) cycle(2'b11, 8'h00, 1'b0, 1'b0);
    cycle(2'b00, 8'hFF, 1'b0, 1'b0);
    cycle(2'b00, 8'hFF, 1'b0, 1'b0);
    check("fl_pending", s_iv, 1);
    check("fl_full", s_free, 0);
    cycle(2'b11, 8'hFF, 1'b1, 1'b1);
    check("fl_no_clr", s_clr, 0);
    check("fl_no_sel", s_sel, 0);
    cycle(2'b00, 8'h00, 1'b0, 1'b0);
    check("fl_free", s_free, 8);
    check("fl_valid", s_iv, 0);
    check("fl_clr_after", s_clr, 0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cycle(2'($urandom_range(0, 3)), 8'($urandom()), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
